// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite command types and the arbiter state encoding.
package axi_lite_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/axi_lite_master_arbiter_rr_pick.sv
// Round-robin picker: first pending requester at or after ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Scan farthest-to-nearest from ptr so the nearest pending requester wins.
  always_comb begin : pick
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    j       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        gnt_oh    = '0;
        gnt_oh[j] = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI4-Lite master between NUM_REQ requesters, round-robin,
// with a watchdog that aborts transactions the master never completes.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for any req_valid; winner's request latched on exit
//   ST_GRANT | one-cycle start_read/start_write pulse to the master
//   ST_WAIT  | waiting for m_done; watchdog counting
//   ST_RESP  | one-cycle req_done to the winner; round-robin pointer advances
module axi_lite_master_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                aclk,
  input  logic                areset_n,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [NUM_REQ-1:0]  req_write,
  input  addr_t [NUM_REQ-1:0] req_addr,
  input  data_t [NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]  req_done,
  output logic                req_err,
  output data_t               req_rdata,
  output logic                start_read,
  output logic                start_write,
  output addr_t               addr,
  output data_t               data,
  input  logic                m_done,
  input  data_t               m_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [NUM_REQ-1:0] g_oh_q, g_oh_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;
  logic               req_err_q, req_err_d;
  data_t              req_rdata_q, req_rdata_d;
  logic               start_read_q, start_read_d;
  logic               start_write_q, start_write_d;
  addr_t              addr_q, addr_d;
  data_t              data_q, data_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    g_d           = g_q;
    g_oh_d        = g_oh_q;
    wd_d          = wd_q;
    req_done_d    = '0;
    req_err_d     = req_err_q;
    req_rdata_d   = req_rdata_q;
    start_read_d  = 1'b0;
    start_write_d = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          // Start pulse is produced here so it is registered during GRANT.
          g_d           = pick_idx;
          g_oh_d        = pick_oh;
          addr_d        = req_addr[pick_idx];
          data_d        = req_wdata[pick_idx];
          start_write_d = req_write[pick_idx];
          start_read_d  = ~req_write[pick_idx];
          state_d       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (m_done) begin
          req_rdata_d = m_rdata;
          req_err_d   = 1'b0;
          req_done_d  = g_oh_q;
          state_d     = ST_RESP;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
          req_rdata_d = '0;
          req_err_d   = 1'b1;
          req_done_d  = g_oh_q;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_ptr_d = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      g_q           <= '0;
      g_oh_q        <= '0;
      wd_q          <= '0;
      req_done_q    <= '0;
      req_err_q     <= 1'b0;
      req_rdata_q   <= '0;
      start_read_q  <= 1'b0;
      start_write_q <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      g_q           <= g_d;
      g_oh_q        <= g_oh_d;
      wd_q          <= wd_d;
      req_done_q    <= req_done_d;
      req_err_q     <= req_err_d;
      req_rdata_q   <= req_rdata_d;
      start_read_q  <= start_read_d;
      start_write_q <= start_write_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
    end
  end

  assign req_done    = req_done_q;
  assign req_err     = req_err_q;
  assign req_rdata   = req_rdata_q;
  assign start_read  = start_read_q;
  assign start_write = start_write_q;
  assign addr        = addr_q;
  assign data        = data_q;

endmodule
